// File: rtl/hp0_wr_arbiter_pkg.sv
// Shared types and constants for the HP0 write-port arbiter.
package hp0_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int         HP0_LEN_W      = 4;

  // Requester WLAST must agree with the beat count derived from AWLEN.
  function automatic logic wlast_mismatch(input logic req_wlast, input logic last_beat);
    return req_wlast ^ last_beat;
  endfunction

endpackage

// File: rtl/hp0_wr_arbiter_rr.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx
);

  // Rotate priority so the requester just served is searched last.
  always_comb begin
    logic             found_s;
    logic [PTR_W-1:0] idx_s;
    gnt     = {N{1'b0}};
    gnt_idx = {PTR_W{1'b0}};
    found_s = 1'b0;
    idx_s   = {PTR_W{1'b0}};
    for (int i = 1; i <= N; i++) begin
      idx_s = PTR_W'((int'(ptr) + i) % N);
      if (!found_s && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        gnt_idx    = idx_s;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/hp0_wr_arbiter.sv
// Round-robin sharing of the HP0 AXI3 write port between NUM_REQ burst masters,
// one complete AW/W/B transaction at a time, with WLAST regeneration and error flags.
module hp0_wr_arbiter
  import hp0_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int LEN_W   = HP0_LEN_W
) (
  input  logic                           aclk,
  input  logic                           rst_n,
  input  logic [NUM_REQ*ADDR_W-1:0]      s_awaddr,
  input  logic [NUM_REQ*LEN_W-1:0]       s_awlen,
  input  logic [NUM_REQ*3-1:0]           s_awsize,
  input  logic [NUM_REQ*2-1:0]           s_awburst,
  input  logic [NUM_REQ-1:0]             s_awvalid,
  output logic [NUM_REQ-1:0]             s_awready,
  input  logic [NUM_REQ*DATA_W-1:0]      s_wdata,
  input  logic [NUM_REQ*(DATA_W/8)-1:0]  s_wstrb,
  input  logic [NUM_REQ-1:0]             s_wlast,
  input  logic [NUM_REQ-1:0]             s_wvalid,
  output logic [NUM_REQ-1:0]             s_wready,
  output logic [NUM_REQ-1:0]             s_bvalid,
  output logic [NUM_REQ*2-1:0]           s_bresp,
  input  logic [NUM_REQ-1:0]             s_bready,
  output logic [ADDR_W-1:0]              m_axi_awaddr,
  output logic [LEN_W-1:0]               m_axi_awlen,
  output logic [2:0]                     m_axi_awsize,
  output logic [1:0]                     m_axi_awburst,
  output logic                           m_axi_awvalid,
  input  logic                           m_axi_awready,
  output logic [DATA_W-1:0]              m_axi_wdata,
  output logic [DATA_W/8-1:0]            m_axi_wstrb,
  output logic                           m_axi_wlast,
  output logic                           m_axi_wvalid,
  input  logic                           m_axi_wready,
  input  logic                           m_axi_bvalid,
  input  logic [1:0]                     m_axi_bresp,
  output logic                           m_axi_bready,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic                           busy_o,
  output logic [1:0]                     err_o,
  input  logic                           clr_err_i
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STRB_W = DATA_W / 8;

  wr_arb_state_t      state_r;
  logic [NUM_REQ-1:0] grant_r;
  logic [PTR_W-1:0]   gidx_r;
  logic [PTR_W-1:0]   ptr_r;
  logic [LEN_W-1:0]   cnt_r;
  logic               busy_r;
  logic [1:0]         err_r;
  logic [1:0]         err_set_s;
  logic [NUM_REQ-1:0] rr_gnt_s;
  logic [PTR_W-1:0]   rr_idx_s;
  logic               aw_hs_s;
  logic               w_hs_s;
  logic               b_hs_s;
  logic               last_beat_s;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req     (s_awvalid),
    .ptr     (ptr_r),
    .gnt     (rr_gnt_s),
    .gnt_idx (rr_idx_s)
  );

  assign grant_o = grant_r;
  assign busy_o  = busy_r;
  assign err_o   = err_r;

  // Downstream channels follow the owner's slice; valids are gated by phase.
  always_comb begin
    m_axi_awaddr  = s_awaddr[int'(gidx_r)*ADDR_W +: ADDR_W];
    m_axi_awlen   = s_awlen[int'(gidx_r)*LEN_W +: LEN_W];
    m_axi_awsize  = s_awsize[int'(gidx_r)*3 +: 3];
    m_axi_awburst = s_awburst[int'(gidx_r)*2 +: 2];
    m_axi_wdata   = s_wdata[int'(gidx_r)*DATA_W +: DATA_W];
    m_axi_wstrb   = s_wstrb[int'(gidx_r)*STRB_W +: STRB_W];
    last_beat_s   = (cnt_r == {LEN_W{1'b0}});
    m_axi_awvalid = (state_r == ADDR) && s_awvalid[gidx_r];
    m_axi_wvalid  = (state_r == DATA) && s_wvalid[gidx_r];
    m_axi_wlast   = (state_r == DATA) && last_beat_s;
    m_axi_bready  = (state_r == RESP) && s_bready[gidx_r];
    aw_hs_s       = m_axi_awvalid && m_axi_awready;
    w_hs_s        = m_axi_wvalid && m_axi_wready;
    b_hs_s        = m_axi_bvalid && m_axi_bready;
    err_set_s[0]  = w_hs_s && wlast_mismatch(s_wlast[gidx_r], last_beat_s);
    err_set_s[1]  = b_hs_s && (m_axi_bresp != AXI_RESP_OKAY);
  end

  // Non-owners always see idle handshake signals and an OKAY-coded response.
  always_comb begin
    s_awready = {NUM_REQ{1'b0}};
    s_wready  = {NUM_REQ{1'b0}};
    s_bvalid  = {NUM_REQ{1'b0}};
    s_bresp   = {(NUM_REQ*2){1'b0}};
    case (state_r)
      ADDR: s_awready[gidx_r] = m_axi_awready;
      DATA: s_wready[gidx_r]  = m_axi_wready;
      RESP: begin
        s_bvalid[gidx_r]                 = m_axi_bvalid;
        s_bresp[int'(gidx_r)*2 +: 2]     = m_axi_bresp;
      end
      default: s_awready = {NUM_REQ{1'b0}};
    endcase
  end

  // Transaction FSM with beat counter and registered grant/busy.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      grant_r <= {NUM_REQ{1'b0}};
      gidx_r  <= {PTR_W{1'b0}};
      ptr_r   <= PTR_W'(NUM_REQ - 1);
      cnt_r   <= {LEN_W{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|s_awvalid) begin
            grant_r <= rr_gnt_s;
            gidx_r  <= rr_idx_s;
            busy_r  <= 1'b1;
            state_r <= ADDR;
          end else begin
            state_r <= IDLE;
          end
        end
        ADDR: begin
          if (aw_hs_s) begin
            cnt_r   <= m_axi_awlen;
            state_r <= DATA;
          end else begin
            state_r <= ADDR;
          end
        end
        DATA: begin
          if (w_hs_s) begin
            cnt_r   <= cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
            state_r <= last_beat_s ? RESP : DATA;
          end else begin
            state_r <= DATA;
          end
        end
        RESP: begin
          if (b_hs_s) begin
            ptr_r   <= gidx_r;
            grant_r <= {NUM_REQ{1'b0}};
            busy_r  <= 1'b0;
            cnt_r   <= {LEN_W{1'b0}};
            state_r <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          grant_r <= {NUM_REQ{1'b0}};
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new error wins over a same-cycle clear.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 2'b00;
    end else if (clr_err_i) begin
      err_r <= err_set_s;
    end else begin
      err_r <= err_r | err_set_s;
    end
  end

endmodule

// File: tb/tb_hp0_wr_arbiter.sv
// Directed bench for hp0_wr_arbiter: a hand-driven pair of masters and an HP0 slave.
module tb_hp0_wr_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int LW = 4;

  logic            aclk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR*AW-1:0] s_awaddr = '0;
  logic [NR*LW-1:0] s_awlen = '0;
  logic [NR*3-1:0]  s_awsize = '0;
  logic [NR*2-1:0]  s_awburst = '0;
  logic [NR-1:0]    s_awvalid = '0;
  logic [NR-1:0]    s_awready;
  logic [NR*DW-1:0] s_wdata = '0;
  logic [NR*8-1:0]  s_wstrb = '0;
  logic [NR-1:0]    s_wlast = '0;
  logic [NR-1:0]    s_wvalid = '0;
  logic [NR-1:0]    s_wready;
  logic [NR-1:0]    s_bvalid;
  logic [NR*2-1:0]  s_bresp;
  logic [NR-1:0]    s_bready = '0;
  logic [AW-1:0]    m_axi_awaddr;
  logic [LW-1:0]    m_axi_awlen;
  logic [2:0]       m_axi_awsize;
  logic [1:0]       m_axi_awburst;
  logic             m_axi_awvalid;
  logic             m_axi_awready = 1'b0;
  logic [DW-1:0]    m_axi_wdata;
  logic [7:0]       m_axi_wstrb;
  logic             m_axi_wlast;
  logic             m_axi_wvalid;
  logic             m_axi_wready = 1'b0;
  logic             m_axi_bvalid = 1'b0;
  logic [1:0]       m_axi_bresp = 2'b00;
  logic             m_axi_bready;
  logic [NR-1:0]    grant_o;
  logic             busy_o;
  logic [1:0]       err_o;
  logic             clr_err_i = 1'b0;

  int total = 0;
  int bad = 0;
  logic [AW-1:0] addr_a [NR];
  logic [LW-1:0] len_a  [NR];

  hp0_wr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .aclk(aclk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
    .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o), .clr_err_i(clr_err_i)
  );

  always #5 aclk = ~aclk;

  function automatic logic [DW-1:0] beat_data(input int r, input int b);
    return {32'hCAFE_0000 + 32'(r), 32'hB000_0000 + 32'(b)};
  endfunction

  task automatic set_req(input int r, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    addr_a[r] = addr;
    len_a[r]  = len;
    s_awaddr[r*AW +: AW] = addr;
    s_awlen[r*LW +: LW]  = len;
    s_awsize[r*3 +: 3]   = 3'd3;
    s_awburst[r*2 +: 2]  = 2'b01;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    rst_n = 1'b0;
    s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    clr_err_i = 1'b0;
    repeat (2) @(negedge aclk);
    rst_n = 1'b1;
  endtask

  // One full transaction by requester exp_r; awvalid must already be raised by the caller.
  task automatic run_txn(input int exp_r, input bit drop_aw, input bit toggle_wready,
                         input int bdelay, input logic [1:0] bresp, input int bad_beat);
    int b;
    int cyc;
    logic [NR-1:0] exp_g;
    logic [NR-1:0] got;
    exp_g = NR'(1) << exp_r;
    cyc = 0;
    do begin
      @(negedge aclk); #1;
      cyc++;
    end while (grant_o == '0 && cyc < 20);
    total++;
    if (grant_o !== exp_g) begin
      bad++; $display("FAIL grant: got %b want %b", grant_o, exp_g);
    end
    m_axi_awready = 1'b1;
    #1;
    total++;
    if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== addr_a[exp_r] || m_axi_awlen !== len_a[exp_r]
        || s_awready !== exp_g) begin
      bad++; $display("FAIL aw_fwd: valid=%b addr=%h len=%0d rdy=%b want addr=%h len=%0d rdy=%b",
                      m_axi_awvalid, m_axi_awaddr, m_axi_awlen, s_awready,
                      addr_a[exp_r], len_a[exp_r], exp_g);
    end
    b = 0;
    cyc = 0;
    while (b <= int'(len_a[exp_r]) && cyc < 100) begin
      @(negedge aclk);
      if (cyc == 0) begin
        m_axi_awready = 1'b0;
        if (drop_aw) s_awvalid[exp_r] = 1'b0;
      end
      s_wvalid[exp_r] = 1'b1;
      s_wdata[exp_r*DW +: DW] = beat_data(exp_r, b);
      s_wstrb[exp_r*8 +: 8]   = 8'hFF ^ 8'(b);
      s_wlast[exp_r] = (b == int'(len_a[exp_r])) || (b == bad_beat);
      m_axi_wready = toggle_wready ? ((cyc % 2) == 0) : 1'b1;
      #1;
      if (m_axi_wready) begin
        total++;
        if (m_axi_wvalid !== 1'b1 || s_wready !== exp_g || m_axi_wdata !== beat_data(exp_r, b)
            || m_axi_wstrb !== (8'hFF ^ 8'(b)) || m_axi_wlast !== (b == int'(len_a[exp_r]))) begin
          bad++; $display("FAIL w_beat%0d: v=%b rdy=%b d=%h s=%h l=%b", b, m_axi_wvalid,
                          s_wready, m_axi_wdata, m_axi_wstrb, m_axi_wlast);
        end
        b++;
      end
      cyc++;
    end
    total++;
    if (b != int'(len_a[exp_r]) + 1) begin
      bad++; $display("FAIL beat_count: got %0d want %0d", b, int'(len_a[exp_r]) + 1);
    end
    @(negedge aclk);
    s_wvalid[exp_r] = 1'b0;
    s_wlast[exp_r]  = 1'b0;
    m_axi_wready = 1'b1;
    s_bready[exp_r] = 1'b1;
    for (int d = 0; d < bdelay; d++) begin
      #1;
      total++;
      if (s_bvalid !== '0 || m_axi_bready !== 1'b1 || busy_o !== 1'b1 || s_wready !== '0) begin
        bad++; $display("FAIL resp_wait%0d: bvalid=%b bready=%b busy=%b wready=%b",
                        d, s_bvalid, m_axi_bready, busy_o, s_wready);
      end
      @(negedge aclk);
    end
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = bresp;
    #1;
    got = s_bvalid;
    total++;
    if (got !== exp_g || s_bresp[exp_r*2 +: 2] !== bresp || s_bresp[(1-exp_r)*2 +: 2] !== 2'b00) begin
      bad++; $display("FAIL b_route: bvalid=%b bresp=%b want bvalid=%b resp=%b",
                      got, s_bresp, exp_g, bresp);
    end
    @(negedge aclk);
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    m_axi_wready = 1'b0;
    s_bready[exp_r] = 1'b0;
    #1;
    total++;
    if (grant_o !== '0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL idle_after_b: grant=%b busy=%b want 00/0", grant_o, busy_o);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (grant_o !== 2'b00 || busy_o !== 1'b0 || err_o !== 2'b00 || m_axi_awvalid !== 1'b0 ||
        m_axi_wvalid !== 1'b0 || m_axi_bready !== 1'b0 || s_awready !== 2'b00 || s_bvalid !== 2'b00) begin
      bad++; $display("FAIL reset_state: grant=%b busy=%b err=%b awv=%b wv=%b br=%b",
                      grant_o, busy_o, err_o, m_axi_awvalid, m_axi_wvalid, m_axi_bready);
    end
  endtask

  task automatic test_single();
    set_req(0, 32'h1000_0000, 4'd3);
    @(negedge aclk);
    s_awvalid[0] = 1'b1;
    run_txn(0, 1'b1, 1'b0, 0, 2'b00, -1);
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_req(0, 32'h1000_0100, 4'd1);
    set_req(1, 32'h2000_0200, 4'd2);
    s_awvalid = 2'b11;
    run_txn(0, 1'b1, 1'b0, 0, 2'b00, -1);
    run_txn(1, 1'b1, 1'b0, 0, 2'b00, -1);
  endtask

  task automatic test_alternation();
    set_req(0, 32'h1000_0300, 4'd0);
    set_req(1, 32'h2000_0400, 4'd1);
    @(negedge aclk);
    s_awvalid = 2'b11;
    run_txn(0, 1'b0, 1'b0, 0, 2'b00, -1);
    run_txn(1, 1'b0, 1'b0, 0, 2'b00, -1);
    run_txn(0, 1'b1, 1'b0, 0, 2'b00, -1);
    run_txn(1, 1'b1, 1'b0, 0, 2'b00, -1);
  endtask

  task automatic test_backpressure();
    set_req(0, 32'h1000_0500, 4'd3);
    @(negedge aclk);
    s_awvalid[0] = 1'b1;
    run_txn(0, 1'b1, 1'b1, 5, 2'b00, -1);
  endtask

  task automatic test_wlast_err();
    set_req(1, 32'h2000_0600, 4'd3);
    @(negedge aclk);
    s_awvalid[1] = 1'b1;
    run_txn(1, 1'b1, 1'b0, 0, 2'b00, 1);
    total++;
    if (err_o !== 2'b01) begin
      bad++; $display("FAIL wlast_err: got %b want 01", err_o);
    end
    clr_err_i = 1'b1;
    @(negedge aclk);
    clr_err_i = 1'b0;
    total++;
    if (err_o !== 2'b00) begin
      bad++; $display("FAIL err_clear: got %b want 00", err_o);
    end
  endtask

  task automatic test_bresp_err();
    set_req(1, 32'h2000_0700, 4'd0);
    @(negedge aclk);
    s_awvalid[1] = 1'b1;
    run_txn(1, 1'b1, 1'b0, 2, 2'b10, -1);
    total++;
    if (err_o !== 2'b10) begin
      bad++; $display("FAIL bresp_err: got %b want 10", err_o);
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc;
    set_req(0, 32'h1000_0800, 4'd3);
    @(negedge aclk);
    s_awvalid[0] = 1'b1;
    cyc = 0;
    do begin
      @(negedge aclk); #1;
      cyc++;
    end while (grant_o == '0 && cyc < 20);
    m_axi_awready = 1'b1;
    @(negedge aclk);
    m_axi_awready = 1'b0;
    s_awvalid[0] = 1'b0;
    s_wvalid[0] = 1'b1;
    m_axi_wready = 1'b1;
    #1;
    total++;
    if (m_axi_wvalid !== 1'b1 || s_wready !== 2'b01) begin
      bad++; $display("FAIL mid_burst_data: wvalid=%b wready=%b", m_axi_wvalid, s_wready);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (m_axi_wvalid !== 1'b0 || s_wready !== 2'b00 || busy_o !== 1'b0 || grant_o !== 2'b00 ||
        err_o !== 2'b00 || m_axi_awvalid !== 1'b0) begin
      bad++; $display("FAIL async_reset: wv=%b wr=%b busy=%b grant=%b err=%b",
                      m_axi_wvalid, s_wready, busy_o, grant_o, err_o);
    end
    s_wvalid = '0;
    m_axi_wready = 1'b0;
    @(negedge aclk);
    rst_n = 1'b1;
    @(negedge aclk); #1;
    total++;
    if (busy_o !== 1'b0 || grant_o !== 2'b00) begin
      bad++; $display("FAIL idle_after_release: busy=%b grant=%b", busy_o, grant_o);
    end
    set_req(0, 32'h1000_0900, 4'd0);
    set_req(1, 32'h2000_0A00, 4'd0);
    s_awvalid = 2'b11;
    run_txn(0, 1'b1, 1'b0, 0, 2'b00, -1);
    run_txn(1, 1'b1, 1'b0, 0, 2'b00, -1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_cycle();
    test_alternation();
    test_backpressure();
    test_wlast_err();
    test_bresp_err();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
